// File: rtl/wam_game_sequencer.sv
// Whack-a-mole game sequencer: restart, ready countdown, play and game-over phases,
// with its own 1 s tick divider and per-mode hit/flick/life/timer bookkeeping.
module wam_game_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int READY_SECS  = 5,
  parameter int GAME_SECS   = 30,
  parameter int HITS_NORMAL = 25,
  parameter int HITS_EXT    = 50,
  parameter int LIVES       = 3,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             ext,
  input  logic             flick,
  input  logic             hit,
  input  logic             expire,
  output logic             load_seed,
  output logic             game_en,
  output logic             clear_n,
  output logic [3:0]       ready_cnt,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] flicks,
  output logic [CNT_W-1:0] target,
  output logic [5:0]       time_left,
  output logic [2:0]       lives_left,
  output logic             game_over,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_READY   = 3'd2,
    S_PLAY    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       ready_q, ready_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] flicks_q, flicks_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [5:0]       time_q, time_d;
  logic [2:0]       lives_q, lives_d;
  logic             run_s, tick_s, pts_in_s, pts_s, timed_s, lives_s, end_s;

  assign run_s    = (state_q == S_READY) || (state_q == S_PLAY);
  assign tick_s   = run_s && (div_q == DIV_LAST);
  assign pts_in_s = (mode == 2'b00) || (mode == 2'b11);
  assign pts_s    = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign timed_s  = (mode_q == 2'b01);
  assign lives_s  = (mode_q == 2'b10);

  // Phase sequencing and counter bookkeeping; start outranks every end condition.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ready_d  = ready_q;
    score_d  = score_q;
    flicks_d = flicks_q;
    target_d = target_q;
    time_d   = time_q;
    lives_d  = lives_q;
    end_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_RESTART : S_IDLE;
      end
      S_RESTART: begin
        mode_d   = mode;
        score_d  = '0;
        flicks_d = '0;
        ready_d  = 4'(READY_SECS);
        target_d = pts_in_s ? (ext ? CNT_W'(HITS_EXT) : CNT_W'(HITS_NORMAL)) : '0;
        time_d   = (mode == 2'b01) ? 6'(GAME_SECS) : 6'd0;
        lives_d  = (mode == 2'b10) ? 3'(LIVES) : 3'd0;
        state_d  = S_READY;
      end
      S_READY: begin
        ready_d = (tick_s && ready_q != 4'd0) ? ready_q - 4'd1 : ready_q;
        if (start) begin
          state_d = S_RESTART;
        end else if (ready_q == 4'd0) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_READY;
        end
      end
      S_PLAY: begin
        flicks_d = (flick && flicks_q != CNT_MAX) ? flicks_q + 1'b1 : flicks_q;
        score_d  = (hit && score_q != CNT_MAX) ? score_q + 1'b1 : score_q;
        lives_d  = (expire && !hit && lives_s && lives_q != 3'd0) ? lives_q - 3'd1 : lives_q;
        time_d   = (tick_s && timed_s && time_q != 6'd0) ? time_q - 6'd1 : time_q;
        end_s    = (pts_s && flicks_d == target_q) ||
                   (timed_s && time_d == 6'd0) ||
                   (lives_s && lives_d == 3'd0);
        if (start) begin
          state_d = S_RESTART;
        end else if (end_s) begin
          state_d = S_OVER;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_OVER: begin
        state_d = start ? S_RESTART : S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tick divider restarts on every phase change so the first tick lands TICK_DIV cycles in.
  always_comb begin
    div_d = '0;
    if (run_s && (state_d == state_q) && !tick_s) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      mode_q   <= 2'b00;
      ready_q  <= 4'd0;
      score_q  <= '0;
      flicks_q <= '0;
      target_q <= '0;
      time_q   <= 6'd0;
      lives_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      ready_q  <= ready_d;
      score_q  <= score_d;
      flicks_q <= flicks_d;
      target_q <= target_d;
      time_q   <= time_d;
      lives_q  <= lives_d;
    end
  end

  assign load_seed  = (state_q == S_IDLE);
  assign game_en    = (state_q == S_PLAY);
  assign clear_n    = (state_q != S_RESTART);
  assign game_over  = (state_q == S_OVER);
  assign state      = state_q;
  assign ready_cnt  = ready_q;
  assign score      = score_q;
  assign flicks     = flicks_q;
  assign target     = target_q;
  assign time_left  = time_q;
  assign lives_left = lives_q;

endmodule
